// File: rtl/or_gate_arbiter.sv
// Round-robin arbiter sharing one OR datapath among N_REQ valid/ready requesters.
// A single registered response port carries each result with the winner's ID.
module or_gate_arbiter #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_REQ-1:0]         REQ_VALID,
   output logic [N_REQ-1:0]         REQ_READY,
   input  logic [N_REQ*WIDTH-1:0]   REQ_IN0,
   input  logic [N_REQ*WIDTH-1:0]   REQ_IN1,
   output logic                     RSP_VALID,
   input  logic                     RSP_READY,
   output logic [WIDTH-1:0]         RSP_OUT,
   output logic [ID_W-1:0]          RSP_ID
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [ID_W-1:0]   r_ptr;
   logic [WIDTH-1:0]  r_rspOut;
   logic [ID_W-1:0]   r_rspId;

   logic              w_found;
   logic [ID_W-1:0]   w_winner;
   logic [ID_W-1:0]   w_cand;
   logic [ID_W-1:0]   w_ptrNext;
   logic [N_REQ-1:0]  w_grant;
   logic [WIDTH-1:0]  w_op0;
   logic [WIDTH-1:0]  w_op1;
   logic [WIDTH-1:0]  w_orResult;
   logic              w_canAccept;
   logic              w_accept;

   // Search PTR, PTR+1, ... with explicit modulo so non-power-of-2 counts wrap correctly
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = int'(r_ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         w_cand = ID_W'(idx);
         if (!w_found && REQ_VALID[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   always_comb begin
      w_grant = '0;
      w_op0   = '0;
      w_op1   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_winner == ID_W'(i)) begin
            w_grant[i] = 1'b1;
            w_op0      = REQ_IN0[i*WIDTH +: WIDTH];
            w_op1      = REQ_IN1[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_orResult  = w_op0 | w_op1;
   assign w_canAccept = (r_state == EMPTY) || RSP_READY;
   assign w_accept    = !RST && w_canAccept && w_found;
   assign REQ_READY   = w_accept ? w_grant : '0;
   assign w_ptrNext   = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

   // A load always leaves us FULL, even when the old response drains in the same edge
   always_comb begin
      w_stateNext = r_state;
      if (w_accept) begin
         w_stateNext = FULL;
      end else if ((r_state == FULL) && RSP_READY) begin
         w_stateNext = EMPTY;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Priority only rotates on a real transfer; draining keeps the last payload visible
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rspOut <= '0;
         r_rspId  <= '0;
         r_ptr    <= '0;
      end else if (w_accept) begin
         r_rspOut <= w_orResult;
         r_rspId  <= w_winner;
         r_ptr    <= w_ptrNext;
      end
   end

   assign RSP_VALID = (r_state == FULL);
   assign RSP_OUT   = r_rspOut;
   assign RSP_ID    = r_rspId;

endmodule
